// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch core: FSM encoding, BCD digit
// maxima and the nibble offsets of each digit inside the packed time word.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_e;

    localparam int DIGIT_W = 4;
    localparam int TIME_W  = 6 * DIGIT_W;

    localparam logic [DIGIT_W-1:0] DIGIT_MAX_9 = 4'd9;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX_5 = 4'd5;

    localparam int OFF_CS_U  = 0;
    localparam int OFF_CS_T  = 4;
    localparam int OFF_SEC_U = 8;
    localparam int OFF_SEC_T = 12;
    localparam int OFF_MIN_U = 16;
    localparam int OFF_MIN_T = 20;

endpackage

// File: rtl/stopwatch_core_if.sv
// Control/status bundle between the stopwatch core and its surroundings.
// master drives clk_1m and the control pulses; slave is the core itself.
interface stopwatch_core_if;
    import stopwatch_pkg::*;

    logic              clk_1m;
    logic              start_stop;
    logic              clear;
    logic              lap;
    logic [TIME_W-1:0] time_bcd;
    logic              running;
    logic              wrap;

    modport master (
        output clk_1m, start_stop, clear, lap,
        input  time_bcd, running, wrap
    );

    modport slave (
        input  clk_1m, start_stop, clear, lap,
        output time_bcd, running, wrap
    );

endinterface

// File: rtl/bcd_digit_cnt.sv
// One BCD digit counting 0..MAX. carry flags the increment that rolls the
// digit over, so chaining carry into the next inc builds a ripple counter.
module bcd_digit_cnt
    import stopwatch_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX = DIGIT_MAX_9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] value,
    output logic               carry
);

    logic [DIGIT_W-1:0] value_q, value_d;

    // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc) begin
            value_d = (value_q >= MAX) ? '0 : value_q + 4'd1;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign carry = inc & (value_q == MAX);

endmodule

// File: rtl/stopwatch_core.sv
// mm:ss.cc stopwatch driven by the sampled 1 MHz divided clock.
// Optional lap hold display is enabled by defining LAP_HOLD_EN.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_CS = 10000,
    parameter int PRE_W        = 14
) (
    input logic             clk,
    input logic             rst,
    stopwatch_core_if.slave sw
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_CS - 1);

    logic              d1_q;
    logic              edge_w;
    sw_state_e         state_q, state_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic              cs_tick;
    logic [5:0]        inc_w, carry_w;
    logic [DIGIT_W-1:0] cs_u, cs_t, sec_u, sec_t, min_u, min_t;
    logic [TIME_W-1:0] live_bcd, disp_bcd, time_bcd_q;
    logic              running_q, wrap_s1_q, wrap_q;

    assign edge_w = sw.clk_1m & ~d1_q;

    always_comb begin
        state_d = state_q;
        if (sw.clear) begin
            state_d = IDLE;
        end else if (sw.start_stop) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // Prescaler keeps its partial count through PAUSE; only clear or rst zero it.
    always_comb begin
        pre_d   = pre_q;
        cs_tick = 1'b0;
        if (sw.clear) begin
            pre_d = '0;
        end else if (state_q == RUN && edge_w) begin
            if (pre_q == PRE_LAST) begin
                pre_d   = '0;
                cs_tick = 1'b1;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    assign inc_w = {carry_w[4:0], cs_tick};

    bcd_digit_cnt #(.MAX(DIGIT_MAX_9)) u_cs_u (
        .clk(clk), .rst(rst), .clr(sw.clear), .inc(inc_w[0]), .value(cs_u),  .carry(carry_w[0])
    );
    bcd_digit_cnt #(.MAX(DIGIT_MAX_9)) u_cs_t (
        .clk(clk), .rst(rst), .clr(sw.clear), .inc(inc_w[1]), .value(cs_t),  .carry(carry_w[1])
    );
    bcd_digit_cnt #(.MAX(DIGIT_MAX_9)) u_sec_u (
        .clk(clk), .rst(rst), .clr(sw.clear), .inc(inc_w[2]), .value(sec_u), .carry(carry_w[2])
    );
    bcd_digit_cnt #(.MAX(DIGIT_MAX_5)) u_sec_t (
        .clk(clk), .rst(rst), .clr(sw.clear), .inc(inc_w[3]), .value(sec_t), .carry(carry_w[3])
    );
    bcd_digit_cnt #(.MAX(DIGIT_MAX_9)) u_min_u (
        .clk(clk), .rst(rst), .clr(sw.clear), .inc(inc_w[4]), .value(min_u), .carry(carry_w[4])
    );
    bcd_digit_cnt #(.MAX(DIGIT_MAX_5)) u_min_t (
        .clk(clk), .rst(rst), .clr(sw.clear), .inc(inc_w[5]), .value(min_t), .carry(carry_w[5])
    );

    always_comb begin
        live_bcd = '0;
        live_bcd[OFF_CS_U  +: DIGIT_W] = cs_u;
        live_bcd[OFF_CS_T  +: DIGIT_W] = cs_t;
        live_bcd[OFF_SEC_U +: DIGIT_W] = sec_u;
        live_bcd[OFF_SEC_T +: DIGIT_W] = sec_t;
        live_bcd[OFF_MIN_U +: DIGIT_W] = min_u;
        live_bcd[OFF_MIN_T +: DIGIT_W] = min_t;
    end

`ifdef LAP_HOLD_EN
    logic              hold_q, hold_d;
    logic [TIME_W-1:0] hold_bcd_q, hold_bcd_d;

    always_comb begin
        hold_d     = hold_q;
        hold_bcd_d = hold_bcd_q;
        if (sw.clear) begin
            hold_d = 1'b0;
        end else if (sw.lap && state_q == RUN) begin
            if (hold_q) begin
                hold_d = 1'b0;
            end else begin
                hold_d     = 1'b1;
                hold_bcd_d = live_bcd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q     <= 1'b0;
            hold_bcd_q <= '0;
        end else begin
            hold_q     <= hold_d;
            hold_bcd_q <= hold_bcd_d;
        end
    end

    assign disp_bcd = hold_q ? hold_bcd_q : live_bcd;
`else
    logic unused_lap;
    assign unused_lap = sw.lap;
    assign disp_bcd   = live_bcd;
`endif

    // wrap is delayed one extra stage so it lines up with the registered display.
    always_ff @(posedge clk) begin
        if (rst) begin
            d1_q       <= 1'b0;
            state_q    <= IDLE;
            pre_q      <= '0;
            time_bcd_q <= '0;
            running_q  <= 1'b0;
            wrap_s1_q  <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            d1_q       <= sw.clk_1m;
            state_q    <= state_d;
            pre_q      <= pre_d;
            time_bcd_q <= disp_bcd;
            running_q  <= (state_d == RUN);
            wrap_s1_q  <= carry_w[5];
            wrap_q     <= wrap_s1_q;
        end
    end

    assign sw.time_bcd = time_bcd_q;
    assign sw.running  = running_q;
    assign sw.wrap     = wrap_q;

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
Consumes the 1 MHz divided clock produced by the clock-divider stage and turns it into a running mm:ss.cc stopwatch time.
- Samples the divided clock as a data signal in the 100 MHz domain and detects its rising edges.
- Prescales those edges to 10 ms ticks and counts BCD centiseconds, seconds and minutes.
- A run/pause/idle FSM is driven by single-cycle control pulses.
- Packed BCD output feeds the seven-segment scan stage downstream.

Parameters:
- TICKS_PER_CS, 10000, number of clk_1m rising edges per centisecond (1 MHz / 100).
- PRE_W, 14, prescaler width; must satisfy 2^PRE_W >= TICKS_PER_CS.

Ports:
- clk  input  1  100 MHz system clock.
- rst  input  1  synchronous reset, active-high.
- clk_1m  input  1  divided clock from the divider stage, sampled as data.
- start_stop  input  1  one-cycle pulse that toggles run/pause.
- clear  input  1  one-cycle pulse that returns the block to IDLE with a zero time.
- lap  input  1  one-cycle pulse for lap hold; used only with LAP_HOLD_EN.
- time_bcd  output  24  {min_t, min_u, sec_t, sec_u, cs_t, cs_u}, 4 bits each, MSB first.
- running  output  1  high while in RUN.
- wrap  output  1  one-cycle pulse when the time rolls over 59:59.99 -> 00:00.00.

Behaviour:
Clock and reset:
- Single clock domain; all state updates on posedge clk.
- rst is synchronous active-high. On reset: FSM=IDLE, prescaler=0, all BCD digits=0, edge register=0, time_bcd=24'h0, running=0, wrap=0, hold state cleared.

Edge detection:
- One register d1 <= clk_1m.
- edge = clk_1m & ~d1 (combinational).
- First edge is possible one cycle after reset if clk_1m is already high; this is accepted.

FSM:
- States: IDLE, RUN, PAUSE.
- IDLE: start_stop -> RUN.
- RUN: start_stop -> PAUSE.
- PAUSE: start_stop -> RUN.
- clear in any state -> IDLE; zeroes the prescaler and all digits in the same cycle.
- clear and start_stop in the same cycle: clear wins, next state is IDLE.
- running = registered (state == RUN).

Prescaler:
- Increments on edge only while in RUN.
- At TICKS_PER_CS-1 with edge: wraps to 0 and asserts internal cs_tick for one cycle.
- Holds its value in PAUSE, so a resume continues the partial count. It is cleared only by IDLE entry or rst.

Digit counting:
- Happens on cs_tick, in the same cycle the prescaler wraps. Ripple chain:
  - cs_u 0-9
  - cs_t 0-9
  - sec_u 0-9
  - sec_t 0-5
  - min_u 0-9
  - min_t 0-5
- Each digit increments only when all lower digits are at their maximum.
- At 59:59.99 a cs_tick produces 00:00.00 and wrap=1 for exactly that cycle. The block stays in RUN.
- Digits never hold non-BCD values.

Latency:
- time_bcd reflects the new count on the clk edge that performs the update, i.e. 1 cycle after the edge-qualifying cycle.
- Total delay from clk_1m rising to the digit change is 2 clk cycles.

Optional Feature:
LAP_HOLD_EN.
- Defined:
  - A lap pulse in RUN with hold off latches the current digits into a hold register and sets hold.
  - Next lap pulse clears hold.
  - While hold=1, time_bcd shows the hold register and counting continues internally.
  - lap in IDLE or PAUSE is ignored.
  - clear and rst both clear hold.
- Not defined: lap is ignored, no hold register exists, and time_bcd always shows the live digits.

Decomposition:
- Shared package stopwatch_pkg holds:
  - State encoding constants (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2).
  - Digit maxima (9, 5).
  - Field offsets within time_bcd.
- One natural sub-module, bcd_digit_cnt. It has parameter MAX and ports clk, rst, clr, inc. It outputs a 4-bit value and carry (carry = inc & value==MAX).
- The top level instantiates bcd_digit_cnt six times.

Test Plan:
All scenarios use TICKS_PER_CS=4 and clk_1m toggling every 50 clk.
- Reset then start_stop, run 4 edges -> cs_u=1 exactly 2 clk after the 4th clk_1m rise; running=1.
- Run 400 edges -> time_bcd=24'h000100; sec_u=1, cs=00.
- Pause after 2 edges, hold 10 edges, resume, 2 more edges -> cs_u=1, i.e. the prescaler was retained across the pause.
- Preload 59:59.99 via 359999 ticks, then 1 more cs_tick -> time_bcd=24'h0, wrap high for one cycle, running stays 1.
- clear and start_stop in the same cycle while in RUN -> IDLE, time_bcd=0, running=0; rst asserted mid-count gives the same result.
- LAP_HOLD_EN: lap at 00:00.05, run 3 more cs -> display stays 24'h000005; second lap -> display 24'h000008.
